filter_controller: RTL and testbench
====================================

// Module: filter_controller
// PURPOSE
//  Sequencing FSM for the FIR datapath; sits directly downstream of coefficient_loader.
//  Services coefficient-load pulses and new-sample requests and drives one datapath op per cycle.
//  Asserts modwait while busy, which is the handshake coefficient_loader and the sample source wait on.
//  Computes out = S1*F0 - S2*F1 + S3*F2 - S4*F3.
// PARAMETERS
//  ADDR_W   4   register-file address width (src1/src2/dest)
//  OP_W     3   datapath opcode width
// PORTS
//  clk              in   1       system clock, rising edge
//  n_reset          in   1       asynchronous active-low reset
//  dr               in   1       data_ready level from sample source, held until modwait rises
//  lc               in   1       load_coeff one-cycle pulse from coefficient_loader
//  coefficient_num  in   2       coefficient index accompanying lc
//  overflow         in   1       datapath ALU overflow, valid in the cycle of the op
//  modwait          out  1       registered busy flag
//  err              out  1       high while in EIDLE
//  cnt_up           out  1       one-cycle pulse per completed sample
//  clear            out  1       one-cycle pulse when coefficient 0 is loaded (restarts sample count)
//  op               out  OP_W    NOP=0 COPY=1 LOAD1=2(sample) LOAD2=3(coeff) ADD=4 SUB=5 MUL=6
//  src1, src2, dest out  ADDR_W  register addresses
// BEHAVIOUR
//  Register map:
//   R0=result; R1..R4=sample history S1..S4; R5=new sample; R6..R9=F0..F3; R10=scratch.
//  Reset: state=IDLE, modwait=0; all other outputs are Moore decodes of state (op=NOP, addrs=0, flags=0).
//  modwait is registered as (next_state not in {IDLE,EIDLE}), so it is 1 exactly in active states.
//  IDLE/EIDLE:
//   - lc has priority -> LCOEF, capturing coefficient_num in a 2-bit register.
//   - else dr -> STORE.
//   - else hold.
//   - err=1 only in EIDLE; EIDLE exits identically to IDLE.
//  LCOEF: op=LOAD2, dest=6+cidx, clear=(cidx==0) -> IDLE. One busy cycle per coefficient.
//   - lc pulses arriving outside IDLE/EIDLE are ignored; the loader cannot issue them because modwait=1.
//  STORE: op=LOAD1, dest=R5.
//   - dr==0 here (sample retracted) -> EIDLE.
//   - else -> SHIFT1.
//  SHIFT1..4: COPY R4<-R3, R3<-R2, R2<-R1, R1<-R5, in that order.
//  MUL1 R10=R1*R6 | COPY0 R0<-R10 | MUL2 R10=R2*R7 | SUB2 R0=R0-R10
//  MUL3 R10=R3*R8 | ADD3 R0=R0+R10 | MUL4 R10=R4*R9 | SUB4 R0=R0-R10, cnt_up=1 -> IDLE.
//  Overflow:
//   - overflow=1 in any of MUL1..SUB4 -> EIDLE next cycle; the remaining ops are abandoned.
//   - cnt_up is not pulsed on the overflow path.
//  Latency: dr seen in IDLE at cycle t -> STORE at t+1, SUB4 at t+13, IDLE with modwait=0 at t+14.
//   - modwait=1 for cycles t+1..t+13.
//  Async reset mid-operation returns to IDLE at once and drops modwait; the partial result is discarded.
//  Simultaneous dr and lc in IDLE:
//   - LCOEF runs first.
//   - dr, still held, is serviced the cycle after returning to IDLE.
// STRUCTURE
//  Package filter_pkg holds:
//   - state_t enum (IDLE, EIDLE, LCOEF, STORE, SHIFT1-4, MUL1, COPY0, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4).
//   - op_t localparams.
//   - register-address localparams R_RES, R_S1..R_S4, R_NEW, R_F0..R_F3, R_TMP.
//  Single module: a state register, a modwait register and a combinational next-state/output decode.
//  No sub-module.
// TESTING
//  1. Reset:
//     - n_reset=0 mid-SHIFT2 -> modwait=0, op=NOP, err=0 immediately.
//     - After release, the FSM stays IDLE with dr=0.
//  2. Coefficient load:
//     - lc pulse with coefficient_num=0 in IDLE -> next cycle op=3, dest=6, clear=1, modwait=1.
//     - Following cycle -> IDLE, modwait=0.
//     - Repeat with coefficient_num=3 -> dest=9, clear=0.
//  3. Loader integration: drive coefficient_loader against this block.
//     - Expect dests 6,7,8,9 in order, each 1 cycle, with no lost lc pulses.
//  4. Sample: F0..F3=1,2,3,4; samples 10,20,30,40,50 (dr held 3 cycles each).
//     - Expect R0=50*1-40*2+30*3-20*4=-20.
//     - Expect cnt_up once per sample at t+13.
//  5. Error paths:
//     - dr dropped during STORE -> EIDLE, err=1.
//     - overflow=1 in ADD3 -> EIDLE, no cnt_up.
//     - Next dr from EIDLE -> STORE and err=0.
//  6. Simultaneous lc and dr in IDLE -> LCOEF, then IDLE for one cycle, then STORE.

Source files
------------

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types and constants for the FIR sequencing controller
// Purpose: state encoding, datapath opcodes and register-file addresses used by filter_controller.
// Ports: none (package).
package filter_pkg;

   typedef enum logic [3:0] {
      IDLE,
      EIDLE,
      LCOEF,
      STORE,
      SHIFT1,
      SHIFT2,
      SHIFT3,
      SHIFT4,
      MUL1,
      COPY0,
      MUL2,
      SUB2,
      MUL3,
      ADD3,
      MUL4,
      SUB4
   } state_t;

   // Datapath opcodes
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_COPY  = 3'd1;
   localparam logic [2:0] OP_LOAD1 = 3'd2;
   localparam logic [2:0] OP_LOAD2 = 3'd3;
   localparam logic [2:0] OP_ADD   = 3'd4;
   localparam logic [2:0] OP_SUB   = 3'd5;
   localparam logic [2:0] OP_MUL   = 3'd6;

   // Register-file map
   localparam logic [3:0] R_RES = 4'd0;
   localparam logic [3:0] R_S1  = 4'd1;
   localparam logic [3:0] R_S2  = 4'd2;
   localparam logic [3:0] R_S3  = 4'd3;
   localparam logic [3:0] R_S4  = 4'd4;
   localparam logic [3:0] R_NEW = 4'd5;
   localparam logic [3:0] R_F0  = 4'd6;
   localparam logic [3:0] R_F1  = 4'd7;
   localparam logic [3:0] R_F2  = 4'd8;
   localparam logic [3:0] R_F3  = 4'd9;
   localparam logic [3:0] R_TMP = 4'd10;

endpackage

// File: rtl/filter_controller.sv
// rtl/filter_controller.sv - sequencing FSM driving one FIR datapath op per cycle
// Purpose: services coefficient loads and new samples, sequencing
//          out = S1*F0 - S2*F1 + S3*F2 - S4*F3 on the register-file datapath.
// Ports:
//   clk, n_reset         clock (rising edge), asynchronous active-low reset
//   dr                   sample ready level, held until modwait rises
//   lc, coefficient_num  coefficient load pulse and its index
//   overflow             datapath overflow for the op of the current cycle
//   modwait              registered busy flag
//   err                  high while in the error-idle state
//   cnt_up               pulse per completed sample
//   clear                pulse when coefficient 0 is loaded
//   op, src1, src2, dest datapath operation and register addresses
module filter_controller
   import filter_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              dr,
   input  logic              lc,
   input  logic [1:0]        coefficient_num,
   input  logic              overflow,
   output logic              modwait,
   output logic              err,
   output logic              cnt_up,
   output logic              clear,
   output logic [OP_W-1:0]   op,
   output logic [ADDR_W-1:0] src1,
   output logic [ADDR_W-1:0] src2,
   output logic [ADDR_W-1:0] dest
);

   state_t     state_q, state_d;
   logic [1:0] cidx_q, cidx_d;
   logic       modwait_q;

   logic [2:0] op_c;
   logic [3:0] src1_c, src2_c, dest_c;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= IDLE;
         cidx_q    <= 2'd0;
         modwait_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cidx_q    <= cidx_d;
         // Registered from next state so busy is visible in the same cycle as the active state.
         modwait_q <= !((state_d == IDLE) || (state_d == EIDLE));
      end
   end

   always_comb begin
      state_d = state_q;
      cidx_d  = cidx_q;
      op_c    = OP_NOP;
      src1_c  = R_RES;
      src2_c  = R_RES;
      dest_c  = R_RES;
      err     = 1'b0;
      cnt_up  = 1'b0;
      clear   = 1'b0;

      case (state_q)
         IDLE, EIDLE: begin
            err = (state_q == EIDLE);
            // Coefficient load wins; a held dr is picked up after LCOEF returns here.
            if (lc) begin
               state_d = LCOEF;
               cidx_d  = coefficient_num;
            end else if (dr) begin
               state_d = STORE;
            end
         end
         LCOEF: begin
            op_c    = OP_LOAD2;
            dest_c  = R_F0 + {2'b00, cidx_q};
            clear   = (cidx_q == 2'd0);
            state_d = IDLE;
         end
         STORE: begin
            op_c    = OP_LOAD1;
            dest_c  = R_NEW;
            state_d = dr ? SHIFT1 : EIDLE;
         end
         // History shift runs oldest-first so no sample is overwritten before it is copied.
         SHIFT1: begin op_c = OP_COPY; src1_c = R_S3;  dest_c = R_S4; state_d = SHIFT2; end
         SHIFT2: begin op_c = OP_COPY; src1_c = R_S2;  dest_c = R_S3; state_d = SHIFT3; end
         SHIFT3: begin op_c = OP_COPY; src1_c = R_S1;  dest_c = R_S2; state_d = SHIFT4; end
         SHIFT4: begin op_c = OP_COPY; src1_c = R_NEW; dest_c = R_S1; state_d = MUL1;   end
         MUL1: begin
            op_c = OP_MUL; src1_c = R_S1; src2_c = R_F0; dest_c = R_TMP; state_d = COPY0;
         end
         COPY0: begin
            op_c = OP_COPY; src1_c = R_TMP; dest_c = R_RES; state_d = MUL2;
         end
         MUL2: begin
            op_c = OP_MUL; src1_c = R_S2; src2_c = R_F1; dest_c = R_TMP; state_d = SUB2;
         end
         SUB2: begin
            op_c = OP_SUB; src1_c = R_RES; src2_c = R_TMP; dest_c = R_RES; state_d = MUL3;
         end
         MUL3: begin
            op_c = OP_MUL; src1_c = R_S3; src2_c = R_F2; dest_c = R_TMP; state_d = ADD3;
         end
         ADD3: begin
            op_c = OP_ADD; src1_c = R_RES; src2_c = R_TMP; dest_c = R_RES; state_d = MUL4;
         end
         MUL4: begin
            op_c = OP_MUL; src1_c = R_S4; src2_c = R_F3; dest_c = R_TMP; state_d = SUB4;
         end
         SUB4: begin
            op_c    = OP_SUB; src1_c = R_RES; src2_c = R_TMP; dest_c = R_RES;
            // A result that overflowed on its final op is not counted.
            cnt_up  = !overflow;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Any arithmetic-phase overflow abandons the sample.
      if ((state_q inside {MUL1, COPY0, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4}) && overflow) begin
         state_d = EIDLE;
      end
   end

   assign modwait = modwait_q;
   assign op      = OP_W'(op_c);
   assign src1    = ADDR_W'(src1_c);
   assign src2    = ADDR_W'(src2_c);
   assign dest    = ADDR_W'(dest_c);

endmodule

// File: tb/tb_filter_controller.sv
// tb/tb_filter_controller.sv - scoreboard bench for filter_controller
module tb_filter_controller;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       dr, lc, overflow;
   logic [1:0] coefficient_num;
   logic       modwait, err, cnt_up, clear;
   logic [2:0] op;
   logic [3:0] src1, src2, dest;

   filter_controller #(.ADDR_W(4), .OP_W(3)) dut (
      .clk(clk), .n_reset(n_reset), .dr(dr), .lc(lc),
      .coefficient_num(coefficient_num), .overflow(overflow),
      .modwait(modwait), .err(err), .cnt_up(cnt_up), .clear(clear),
      .op(op), .src1(src1), .src2(src2), .dest(dest)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Datapath stand-in and reference model
   int rf [0:15];
   int coef [4];
   int hist [4];
   int sample_bus;

   int exp_dest_q[$], exp_clr_q[$], exp_ccyc_q[$];
   int exp_res_q[$], exp_rcyc_q[$];

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: executes the op on the model register file, then pops expectations.
   always @(negedge clk) begin
      if (n_reset) begin
         case (op)
            3'd1: rf[dest] = rf[src1];
            3'd2: rf[dest] = sample_bus;
            3'd3: if (dest >= 4'd6 && dest <= 4'd9) rf[dest] = coef[dest - 4'd6];
            3'd4: rf[dest] = rf[src1] + rf[src2];
            3'd5: rf[dest] = rf[src1] - rf[src2];
            3'd6: rf[dest] = rf[src1] * rf[src2];
            default: ;
         endcase
         chk("busy_vs_op", int'(modwait), int'(op != 3'd0));
         if (op == 3'd3) begin
            if (exp_dest_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_load2: got dest %0d expected none (cycle %0d)", dest, cyc);
            end else begin
               chk("coef_dest", int'(dest), exp_dest_q.pop_front());
               chk("coef_clear", int'(clear), exp_clr_q.pop_front());
               chk("coef_cycle", cyc, exp_ccyc_q.pop_front());
            end
         end else begin
            chk("clear_spurious", int'(clear), 0);
         end
         if (cnt_up) begin
            if (exp_res_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_cnt_up: got pulse expected none (cycle %0d)", cyc);
            end else begin
               chk("fir_out", rf[0], exp_res_q.pop_front());
               chk("cnt_up_cycle", cyc, exp_rcyc_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40; n++) begin
         if (!modwait) return;
         step();
      end
      total++; bad++;
      $display("FAIL idle_timeout: got modwait=1 expected 0 within 40 cycles");
   endtask

   function automatic int fir_expect();
      return hist[0]*coef[0] - hist[1]*coef[1] + hist[2]*coef[2] - hist[3]*coef[3];
   endfunction

   function automatic void push_hist(int v);
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v;
   endfunction

   task automatic load_coef(int idx, int val);
      int k;
      wait_idle();
      k = cyc;
      lc = 1'b1;
      coefficient_num = 2'(idx);
      coef[idx] = val;
      exp_dest_q.push_back(6 + idx);
      exp_clr_q.push_back(idx == 0);
      exp_ccyc_q.push_back(k + 1);
      step();
      lc = 1'b0;
      chk("lcoef_busy", int'(modwait), 1);
      step();
      chk("lcoef_done_idle", int'(modwait), 0);
   endtask

   // mode 0: normal, 1: dr retracted in STORE, 2: overflow at offset ovf_at, 3: reset in SHIFT2
   task automatic do_sample(int val, int hold, int mode, int ovf_at);
      int k;
      wait_idle();
      k = cyc;
      sample_bus = val;
      dr = 1'b1;
      if (mode == 1) hold = 1;
      if (mode == 0 || mode == 2) push_hist(val);
      if (mode == 0) begin
         exp_res_q.push_back(fir_expect());
         exp_rcyc_q.push_back(k + 13);
      end
      for (int i = 1; i <= 14; i++) begin
         step();
         if (i == hold) dr = 1'b0;
         if (mode == 2 && i == ovf_at) overflow = 1'b1;
         if (i == 1) begin
            chk("store_op", int'(op), 2);
            chk("store_dest", int'(dest), 5);
            chk("store_err", int'(err), 0);
         end
         if (mode == 1 && i == 2) begin
            chk("retract_err", int'(err), 1);
            chk("retract_busy", int'(modwait), 0);
            break;
         end
         if (mode == 2 && i == ovf_at + 1) begin
            overflow = 1'b0;
            chk("ovf_err", int'(err), 1);
            chk("ovf_busy", int'(modwait), 0);
            chk("ovf_op", int'(op), 0);
            break;
         end
         if (mode == 3 && i == 3) begin
            chk("shift2_op", int'(op), 1);
            chk("shift2_src", int'(src1), 2);
            #2 n_reset = 1'b0;
            #1;
            chk("rst_busy", int'(modwait), 0);
            chk("rst_op", int'(op), 0);
            chk("rst_err", int'(err), 0);
            dr = 1'b0;
            break;
         end
         if (mode == 0 && i == 13) chk("busy_t13", int'(modwait), 1);
         if (mode == 0 && i == 14) begin
            chk("idle_t14", int'(modwait), 0);
            chk("idle_t14_err", int'(err), 0);
         end
      end
      dr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200us");
      $fatal(1);
   end

   initial begin
      int k;
      for (int i = 0; i < 16; i++) rf[i] = 0;
      for (int i = 0; i < 4; i++) begin coef[i] = 0; hist[i] = 0; end
      sample_bus = 0;
      n_reset = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0; coefficient_num = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(modwait), 0);
      chk("reset_op", int'(op), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_dest", int'(dest), 0);
      chk("reset_cnt_up", int'(cnt_up), 0);
      n_reset = 1'b1;
      step();

      // Reset mid-operation; only R5 changed in the model datapath, history stays zero.
      do_sample(7, 3, 3, 0);
      step();
      n_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_idle", int'(modwait), 0);
         chk("post_rst_op", int'(op), 0);
      end

      // Coefficient loads including the clear case, then back-to-back loader sequence F=1..4.
      load_coef(0, 9);
      load_coef(3, 5);
      for (int i = 0; i < 4; i++) load_coef(i, i + 1);

      // Known-answer samples.
      for (int i = 1; i <= 5; i++) do_sample(10 * i, 3, 0, 0);
      chk("known_answer", rf[0], -20);

      // Error paths, each followed by recovery from EIDLE.
      do_sample(11, 1, 1, 0);
      do_sample(12, 3, 2, 11);
      do_sample(13, 2, 0, 0);

      // Simultaneous lc and dr.
      wait_idle();
      k = cyc;
      lc = 1'b1; coefficient_num = 2'd1; coef[1] = -3;
      exp_dest_q.push_back(7); exp_clr_q.push_back(0); exp_ccyc_q.push_back(k + 1);
      dr = 1'b1; sample_bus = 33;
      push_hist(33);
      exp_res_q.push_back(fir_expect()); exp_rcyc_q.push_back(k + 15);
      step(); lc = 1'b0;
      chk("sim_lcoef_op", int'(op), 3);
      step();
      chk("sim_gap_busy", int'(modwait), 0);
      chk("sim_gap_op", int'(op), 0);
      step();
      chk("sim_store_op", int'(op), 2);
      step(); dr = 1'b0;

      // Randomized mix.
      for (int n = 0; n < 40; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 2)
            load_coef(int'($urandom_range(0, 3)), int'($urandom_range(0, 16)) - 8);
         else if (r == 2)
            do_sample(int'($urandom_range(0, 200)) - 100, 1, 1, 0);
         else if (r == 3)
            do_sample(int'($urandom_range(0, 200)) - 100, 3, 2, int'($urandom_range(6, 13)));
         else
            do_sample(int'($urandom_range(0, 200)) - 100, int'($urandom_range(2, 5)), 0, 0);
      end

      wait_idle();
      repeat (3) step();
      chk("coef_q_drained", exp_dest_q.size(), 0);
      chk("res_q_drained", exp_res_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
